shift_ring_ctrl: RTL

//  Sequencer for a STAGES-deep rotating shift ring (stage0->stage1->...->stageN-1->stage0).

---
 rtl/shift_ring_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/shift_ring_ctrl.sv
// Command-driven rotating shift ring: load a word, rotate it a counted number of cycles, hand back the result.
// Optional macro SHIFT_RING_BIDIR_EN adds the cmd_dir port and a latched rotate direction.
module shift_ring_ctrl #(
    parameter int STAGES = 4,
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [STAGES*DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]         cmd_count,
`ifdef SHIFT_RING_BIDIR_EN
    input  logic                     cmd_dir,
`endif
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [STAGES*DATA_W-1:0] res_data
);

    localparam int RW = STAGES * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    ring_q,  ring_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [RW-1:0]    rot_up;

`ifdef SHIFT_RING_BIDIR_EN
    logic             dir_q, dir_d;
    logic [RW-1:0]    rot_down;
    // Down: stage[N-1] takes stage[0], every other stage takes its upper neighbour.
    assign rot_down = {ring_q[DATA_W-1:0], ring_q[RW-1:DATA_W]};
`endif

    // Up: stage[0] takes stage[N-1], every other stage takes its lower neighbour.
    assign rot_up = {ring_q[RW-DATA_W-1:0], ring_q[RW-1 -: DATA_W]};

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        ring_d  = ring_q;
        cnt_d   = cnt_q;
`ifdef SHIFT_RING_BIDIR_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ring_d  = cmd_data;
                    cnt_d   = cmd_count;
`ifdef SHIFT_RING_BIDIR_EN
                    dir_d   = cmd_dir;
`endif
                    state_d = (cmd_count == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef SHIFT_RING_BIDIR_EN
                ring_d = dir_q ? rot_down : rot_up;
`else
                ring_d = rot_up;
`endif
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ring_q  <= '0;
            cnt_q   <= '0;
`ifdef SHIFT_RING_BIDIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT_RING_BIDIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_SHIFT);
    assign res_valid = (state_q == S_DONE);
    assign res_data  = ring_q;

endmodule
